// File: rtl/frv_pipeline_stage_buffer_pkg.sv
// Shared types and constants for the backend inter-stage buffer: register-index width,
// zero-register index, transfer encoding and the rd match helper.
package frv_pipeline_stage_buffer_pkg;

    localparam int RD_W = 5;

    typedef logic [RD_W-1:0] rd_t;

    localparam rd_t RD_ZERO = '0;

    // {push, pop} for one cycle; drives the occupancy update.
    typedef enum logic [1:0] {
        XFER_IDLE = 2'b00,
        XFER_POP  = 2'b01,
        XFER_PUSH = 2'b10,
        XFER_BOTH = 2'b11
    } xfer_e;

    // x0 is never a real producer, so a query for it must never report a hazard.
    function automatic logic rd_match(input rd_t entry_rd, input rd_t query);
        return (entry_rd == query) && (query != RD_ZERO);
    endfunction

endpackage

// File: rtl/frv_pipeline_stage_buffer_hazard.sv
// DEPTH-way destination-register comparator with two query ports; each hit is the
// OR over valid entries whose rd equals the (non-zero) query.
module frv_pipeline_stage_buffer_hazard
    import frv_pipeline_stage_buffer_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  rd_t              entry_rd [DEPTH],
    input  logic [DEPTH-1:0] entry_vld,
    input  rd_t              rs1,
    input  rd_t              rs2,
    output logic             rs1_hit,
    output logic             rs2_hit
);

    always_comb begin
        rs1_hit = 1'b0;
        rs2_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            rs1_hit = rs1_hit | (entry_vld[i] & rd_match(entry_rd[i], rs1));
            rs2_hit = rs2_hit | (entry_vld[i] & rd_match(entry_rd[i], rs2));
        end
    end

endmodule

// File: rtl/frv_pipeline_stage_buffer.sv
// DEPTH-entry FIFO hand-off between backend stages with flush and rd hazard lookup.
// Define FRV_PIPE_STAGE_BYPASS_EN for a zero-latency pass-through when the buffer is empty.
module frv_pipeline_stage_buffer
    import frv_pipeline_stage_buffer_pkg::*;
#(
    parameter int W     = 32,
    parameter int DEPTH = 2
) (
    input  logic                       g_clk,
    input  logic                       g_reset,
    input  logic                       flush,
    input  logic                       i_valid,
    output logic                       i_busy,
    input  logic [RD_W-1:0]            i_rd,
    input  logic [W-1:0]               i_data,
    output logic                       o_valid,
    input  logic                       o_busy,
    output logic [RD_W-1:0]            o_rd,
    output logic [W-1:0]               o_data,
    input  logic [RD_W-1:0]            haz_rs1,
    input  logic [RD_W-1:0]            haz_rs2,
    output logic                       haz_rs1_hit,
    output logic                       haz_rs2_hit,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    rd_t            mem_rd_q   [DEPTH];
    logic [W-1:0]   mem_data_q [DEPTH];

    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q,  count_d;
    logic           busy_q,   busy_d;

    logic           bypass;
    logic           push;
    logic           push_wr;
    logic           pop;
    xfer_e          xfer;
    logic [DEPTH-1:0] entry_vld;

`ifdef FRV_PIPE_STAGE_BYPASS_EN
    assign bypass = (count_q == '0) && i_valid && !o_busy && !flush && !g_reset;
`else
    assign bypass = 1'b0;
`endif

    // i_busy is a flop so o_busy never reaches it combinationally.
    assign i_busy  = busy_q || g_reset;
    assign push    = i_valid && !i_busy && !flush;
    assign push_wr = push && !bypass;
    assign pop     = (count_q != '0) && !o_busy;
    assign xfer    = xfer_e'({push_wr, pop});

    assign o_valid = (count_q != '0) || bypass;
    assign o_rd    = bypass ? i_rd   : mem_rd_q[rd_ptr_q];
    assign o_data  = bypass ? i_data : mem_data_q[rd_ptr_q];
    assign count   = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_wr) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)     rd_ptr_d = rd_ptr_q + PW'(1);
            unique case (xfer)
                XFER_PUSH: count_d = count_q + CW'(1);
                XFER_POP:  count_d = count_q - CW'(1);
                default:   count_d = count_q;
            endcase
        end
        busy_d = (count_d == FULL_CNT);
    end

    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            busy_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            busy_q   <= busy_d;
        end
    end

    // Payload storage is deliberately not reset; occupancy alone qualifies it.
    always_ff @(posedge g_clk) begin
        if (push_wr) begin
            mem_rd_q[wr_ptr_q]   <= i_rd;
            mem_data_q[wr_ptr_q] <= i_data;
        end
    end

    // An entry is live when its distance from the read pointer is below the occupancy.
    always_comb begin
        entry_vld = '0;
        for (int i = 0; i < DEPTH; i++) begin
            entry_vld[i] = (CW'(PW'(PW'(i) - rd_ptr_q)) < count_q);
        end
    end

    frv_pipeline_stage_buffer_hazard #(
        .DEPTH (DEPTH)
    ) u_hazard (
        .entry_rd  (mem_rd_q),
        .entry_vld (entry_vld),
        .rs1       (haz_rs1),
        .rs2       (haz_rs2),
        .rs1_hit   (haz_rs1_hit),
        .rs2_hit   (haz_rs2_hit)
    );

endmodule

// File: tb/tb_frv_pipeline_stage_buffer.sv
// Directed bench for frv_pipeline_stage_buffer (W=32, DEPTH=2); honours FRV_PIPE_STAGE_BYPASS_EN.
module tb_frv_pipeline_stage_buffer;

    logic        g_clk = 1'b0;
    logic        g_reset, flush, i_valid, i_busy, o_valid, o_busy;
    logic [4:0]  i_rd, o_rd, haz_rs1, haz_rs2;
    logic [31:0] i_data, o_data;
    logic        haz_rs1_hit, haz_rs2_hit;
    logic [1:0]  count;

    int errors = 0;
    int checks = 0;

    frv_pipeline_stage_buffer #(.W(32), .DEPTH(2)) dut (
        .g_clk       (g_clk),
        .g_reset     (g_reset),
        .flush       (flush),
        .i_valid     (i_valid),
        .i_busy      (i_busy),
        .i_rd        (i_rd),
        .i_data      (i_data),
        .o_valid     (o_valid),
        .o_busy      (o_busy),
        .o_rd        (o_rd),
        .o_data      (o_data),
        .haz_rs1     (haz_rs1),
        .haz_rs2     (haz_rs2),
        .haz_rs1_hit (haz_rs1_hit),
        .haz_rs2_hit (haz_rs2_hit),
        .count       (count)
    );

    always #5 g_clk = ~g_clk;

    task automatic step();
        @(posedge g_clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] rd, input logic [31:0] d);
        i_valid = v;
        i_rd    = rd;
        i_data  = d;
    endtask

    task automatic test_reset();
        g_reset = 1'b1; flush = 1'b0; o_busy = 1'b0;
        drive(1'b0, 5'd0, 32'h0);
        haz_rs1 = 5'd5; haz_rs2 = 5'd0;
        step(); step();
        checks++; if (i_busy !== 1'b1) begin errors++; $display("FAIL reset_ibusy: got %b want 1", i_busy); end
        g_reset = 1'b0;
        step();
        checks++; if (count !== 2'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_ovalid: got %b want 0", o_valid); end
        checks++; if (i_busy !== 1'b0) begin errors++; $display("FAIL reset_ibusy_rel: got %b want 0", i_busy); end
        checks++; if (haz_rs1_hit !== 1'b0 || haz_rs2_hit !== 1'b0) begin errors++; $display("FAIL reset_hits: got %b%b want 00", haz_rs1_hit, haz_rs2_hit); end
    endtask

    task automatic test_single();
        o_busy = 1'b1;
        drive(1'b1, 5'd5, 32'hA5);
        step();
        drive(1'b0, 5'd0, 32'h0);
        checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL single_ovalid: got %b want 1", o_valid); end
        checks++; if (o_rd !== 5'd5) begin errors++; $display("FAIL single_ord: got %0d want 5", o_rd); end
        checks++; if (o_data !== 32'hA5) begin errors++; $display("FAIL single_odata: got %h want a5", o_data); end
        checks++; if (count !== 2'd1) begin errors++; $display("FAIL single_count: got %0d want 1", count); end
        o_busy = 1'b0;
        step();
        checks++; if (count !== 2'd0 || o_valid !== 1'b0) begin errors++; $display("FAIL single_drain: got count=%0d ov=%b want 0/0", count, o_valid); end
    endtask

    task automatic test_back_to_back();
        o_busy = 1'b1;
        drive(1'b1, 5'd1, 32'h11);
        step();
        checks++; if (count !== 2'd1 || i_busy !== 1'b0) begin errors++; $display("FAIL b2b_first: got count=%0d ib=%b want 1/0", count, i_busy); end
        drive(1'b1, 5'd2, 32'h22);
        step();
        checks++; if (count !== 2'd2 || i_busy !== 1'b1) begin errors++; $display("FAIL b2b_full: got count=%0d ib=%b want 2/1", count, i_busy); end
        drive(1'b1, 5'd3, 32'h33);
        step();
        checks++; if (count !== 2'd2 || o_rd !== 5'd1 || o_data !== 32'h11) begin errors++; $display("FAIL b2b_hold: got count=%0d rd=%0d data=%h want 2/1/11", count, o_rd, o_data); end
        drive(1'b0, 5'd0, 32'h0);
        o_busy = 1'b0;
        step();
        checks++; if (o_rd !== 5'd2 || o_data !== 32'h22 || count !== 2'd1) begin errors++; $display("FAIL b2b_order: got rd=%0d data=%h count=%0d want 2/22/1", o_rd, o_data, count); end
        step();
        checks++; if (count !== 2'd0 || o_valid !== 1'b0 || i_busy !== 1'b0) begin errors++; $display("FAIL b2b_empty: got count=%0d ov=%b ib=%b want 0/0/0", count, o_valid, i_busy); end
    endtask

    task automatic test_full_pop_push();
        o_busy = 1'b1;
        drive(1'b1, 5'd4, 32'h41); step();
        drive(1'b1, 5'd5, 32'h42); step();
        o_busy = 1'b0;
        drive(1'b1, 5'd6, 32'h43);
        checks++; if (i_busy !== 1'b1 || count !== 2'd2) begin errors++; $display("FAIL fpp_full: got ib=%b count=%0d want 1/2", i_busy, count); end
        step();
        checks++; if (count !== 2'd1 || i_busy !== 1'b0 || o_data !== 32'h42) begin errors++; $display("FAIL fpp_popn: got count=%0d ib=%b data=%h want 1/0/42", count, i_busy, o_data); end
        step();
        checks++; if (count !== 2'd1 || o_data !== 32'h43 || o_rd !== 5'd6) begin errors++; $display("FAIL fpp_pushn1: got count=%0d data=%h rd=%0d want 1/43/6", count, o_data, o_rd); end
        drive(1'b0, 5'd0, 32'h0);
        step();
        checks++; if (count !== 2'd0) begin errors++; $display("FAIL fpp_drain: got %0d want 0", count); end
    endtask

    task automatic test_hazard();
        o_busy = 1'b1; haz_rs1 = 5'd7; haz_rs2 = 5'd0;
        drive(1'b1, 5'd7, 32'h70);
        checks++; if (haz_rs1_hit !== 1'b0) begin errors++; $display("FAIL haz_input_excluded: got %b want 0", haz_rs1_hit); end
        step();
        drive(1'b1, 5'd0, 32'h71);
        step();
        drive(1'b0, 5'd0, 32'h0);
        checks++; if (haz_rs1_hit !== 1'b1) begin errors++; $display("FAIL haz_rs1_hit: got %b want 1", haz_rs1_hit); end
        checks++; if (haz_rs2_hit !== 1'b0) begin errors++; $display("FAIL haz_rs2_zero: got %b want 0", haz_rs2_hit); end
        haz_rs2 = 5'd7;
        #1;
        checks++; if (haz_rs2_hit !== 1'b1) begin errors++; $display("FAIL haz_rs2_hit: got %b want 1", haz_rs2_hit); end
        haz_rs2 = 5'd0;
        o_busy = 1'b0;
        step();
        o_busy = 1'b1;
        checks++; if (count !== 2'd1 || haz_rs1_hit !== 1'b0) begin errors++; $display("FAIL haz_after_pop: got count=%0d hit=%b want 1/0", count, haz_rs1_hit); end
        o_busy = 1'b0;
        step();
    endtask

    task automatic test_flush();
        o_busy = 1'b1;
        drive(1'b1, 5'd8, 32'h81); step();
        drive(1'b1, 5'd9, 32'h82); step();
        flush = 1'b1;
        drive(1'b1, 5'd12, 32'h99);
        step();
        flush = 1'b0;
        drive(1'b0, 5'd0, 32'h0);
        checks++; if (count !== 2'd0 || o_valid !== 1'b0 || i_busy !== 1'b0) begin errors++; $display("FAIL flush_full: got count=%0d ov=%b ib=%b want 0/0/0", count, o_valid, i_busy); end
        drive(1'b1, 5'd10, 32'hA0); step();
        flush = 1'b1; o_busy = 1'b0;
        drive(1'b1, 5'd11, 32'hB0);
        step();
        flush = 1'b0; o_busy = 1'b1;
        drive(1'b0, 5'd0, 32'h0);
        checks++; if (count !== 2'd0 || o_valid !== 1'b0) begin errors++; $display("FAIL flush_push_pop: got count=%0d ov=%b want 0/0", count, o_valid); end
        step();
        checks++; if (o_valid !== 1'b0 || count !== 2'd0) begin errors++; $display("FAIL flush_push_lost: got ov=%b count=%0d want 0/0", o_valid, count); end
    endtask

    task automatic test_latency();
        o_busy = 1'b0; haz_rs1 = 5'd9;
        drive(1'b1, 5'd9, 32'h900);
        #1;
`ifdef FRV_PIPE_STAGE_BYPASS_EN
        checks++; if (o_valid !== 1'b1 || o_rd !== 5'd9 || o_data !== 32'h900) begin errors++; $display("FAIL lat_bypass: got ov=%b rd=%0d data=%h want 1/9/900", o_valid, o_rd, o_data); end
        checks++; if (haz_rs1_hit !== 1'b0) begin errors++; $display("FAIL lat_bypass_haz: got %b want 0", haz_rs1_hit); end
        step();
        drive(1'b0, 5'd0, 32'h0);
        checks++; if (count !== 2'd0 || o_valid !== 1'b0) begin errors++; $display("FAIL lat_bypass_count: got count=%0d ov=%b want 0/0", count, o_valid); end
`else
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL lat_same_cycle: got %b want 0", o_valid); end
        step();
        drive(1'b0, 5'd0, 32'h0);
        checks++; if (o_valid !== 1'b1 || o_rd !== 5'd9 || count !== 2'd1) begin errors++; $display("FAIL lat_next_cycle: got ov=%b rd=%0d count=%0d want 1/9/1", o_valid, o_rd, count); end
        step();
        checks++; if (count !== 2'd0) begin errors++; $display("FAIL lat_drain: got %0d want 0", count); end
`endif
    endtask

    task automatic test_reset_midstream();
        o_busy = 1'b1; haz_rs1 = 5'd13;
        drive(1'b1, 5'd13, 32'hD0); step();
        drive(1'b1, 5'd14, 32'hD1); step();
        drive(1'b0, 5'd0, 32'h0);
        g_reset = 1'b1;
        step();
        checks++; if (i_busy !== 1'b1 || count !== 2'd0 || o_valid !== 1'b0) begin errors++; $display("FAIL rst_mid: got ib=%b count=%0d ov=%b want 1/0/0", i_busy, count, o_valid); end
        g_reset = 1'b0;
        step();
        checks++; if (i_busy !== 1'b0 || haz_rs1_hit !== 1'b0) begin errors++; $display("FAIL rst_mid_rel: got ib=%b hit=%b want 0/0", i_busy, haz_rs1_hit); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_full_pop_push();
        test_hazard();
        test_flush();
        test_latency();
        test_reset_midstream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1);
    end

endmodule
